// File: rtl/shift_right_multicycle_if.sv
// Start/ready handshake bundle for the multicycle right shifter.
interface shift_right_multicycle_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SW    = 5
);
  logic             ctrl_shift;
  logic             ctrl_arith;
  logic [WIDTH-1:0] data_operandA;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] data_result;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_shift, ctrl_arith, data_operandA, shamt,
    input  data_result, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_shift, ctrl_arith, data_operandA, shamt,
    output data_result, data_resultRDY, busy
  );
endinterface

// File: rtl/shift_right_multicycle.sv
// Multicycle logical/arithmetic right shifter, one log2 stage per clock.
// Optional SHIFT_EARLY_DONE_EN: finish as soon as no higher shamt bits remain.
module shift_right_multicycle #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SW    = 5
) (
  input logic                     clock,
  input logic                     reset,
  shift_right_multicycle_if.slave bus
);

  localparam int unsigned CW = $clog2(SW + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SW-1:0]    shamt_q, shamt_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             fill_in;
  logic [WIDTH-1:0] cap_val;
  logic [WIDTH-1:0] stage_val [SW];
  logic [WIDTH-1:0] stage_out;
  logic             last_cap;
  logic             last_shift;

  function automatic logic [WIDTH-1:0] shr_fill(input logic [WIDTH-1:0] v,
                                                input int unsigned amt, input logic fill);
    logic [2*WIDTH-1:0] ext;
    ext = {{WIDTH{fill}}, v} >> amt;
    return ext[WIDTH-1:0];
  endfunction

  assign fill_in = bus.ctrl_arith & bus.data_operandA[WIDTH-1];
  // Stage 0 is applied directly to the incoming operand on the capture edge.
  assign cap_val = bus.shamt[0] ? shr_fill(bus.data_operandA, 1, fill_in) : bus.data_operandA;

  assign stage_val[0] = work_q;
  for (genvar k = 1; k < SW; k++) begin : g_stage
    assign stage_val[k] = shamt_q[k] ? shr_fill(work_q, 32'(1) << k, fill_q) : work_q;
  end

  assign stage_out = stage_val[cnt_q];

`ifdef SHIFT_EARLY_DONE_EN
  assign last_cap   = (bus.shamt >> 1) == '0;
  assign last_shift = (shamt_q >> (cnt_q + CW'(1))) == '0;
`else
  assign last_cap   = 1'b0;
  assign last_shift = (cnt_q == CW'(SW - 1));
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    shamt_d  = shamt_q;
    fill_d   = fill_q;
    result_d = result_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.ctrl_shift) begin
          shamt_d = bus.shamt;
          fill_d  = fill_in;
          work_d  = cap_val;
          cnt_d   = CW'(1);
          if (last_cap) begin
            state_d  = StDone;
            result_d = cap_val;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        work_d = stage_out;
        cnt_d  = cnt_q + CW'(1);
        if (last_shift) begin
          state_d  = StDone;
          result_d = stage_out;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      work_q   <= '0;
      shamt_q  <= '0;
      fill_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      shamt_q  <= shamt_d;
      fill_q   <= fill_d;
      result_q <= result_d;
    end
  end

  assign bus.busy           = (state_q == StShift);
  assign bus.data_resultRDY = (state_q == StDone);
  assign bus.data_result    = result_q;

endmodule
